// File: rtl/matrix_entry_collector_if.sv
// Element stream between a matrix source and matrix_entry_collector.
// The master drives valid/data; the slave (collector) answers with ready.
interface matrix_entry_collector_if #(
  parameter int ELEM_WIDTH = 8
) ();

  logic                  elem_valid;
  logic [ELEM_WIDTH-1:0] elem_data;
  logic                  elem_ready;

  modport master (
    output elem_valid,
    output elem_data,
    input  elem_ready
  );

  modport slave (
    input  elem_valid,
    input  elem_data,
    output elem_ready
  );

endinterface

// File: rtl/matrix_entry_collector.sv
// Collects an m x n matrix element by element (row-major) into a packed
// MAX_DIM x MAX_DIM bus. Optional element range check: MATRIX_RANGE_CHECK_EN.
module matrix_entry_collector #(
  parameter int MAX_DIM    = 5,
  parameter int ELEM_WIDTH = 8,
  parameter int MAX_VAL    = 9
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [2:0]                            m_in,
  input  logic [2:0]                            n_in,
  matrix_entry_collector_if.slave               elem_if,
  input  logic                                  consume,
  output logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0] matrix_out,
  output logic [2:0]                            m_out,
  output logic [2:0]                            n_out,
  output logic                                  done,
  output logic                                  busy,
  output logic [4:0]                            count,
  output logic                                  err_dim,
  output logic                                  err_val
);

  localparam int CELLS = MAX_DIM * MAX_DIM;

`ifdef MATRIX_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CELLS-1:0][ELEM_WIDTH-1:0] matrix_q, matrix_d;
  logic [2:0] m_q, m_d;
  logic [2:0] n_q, n_d;
  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic [4:0] count_q, count_d;
  logic       elem_ready_q, elem_ready_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       err_dim_q, err_dim_d;
  logic       err_val_q, err_val_d;

  logic       dims_ok;
  logic       over_max;
  logic       elem_reject;
  logic [4:0] cell_idx;

  assign dims_ok = (m_in != 3'd0) && (n_in != 3'd0) &&
                   (m_in <= 3'(MAX_DIM)) && (n_in <= 3'(MAX_DIM));

  // Without the range check the comparison is still evaluated but never acted on.
  assign over_max    = elem_if.elem_data > ELEM_WIDTH'(MAX_VAL);
  assign elem_reject = RANGE_CHECK && over_max;

  assign cell_idx = 5'(row_q) * 5'(MAX_DIM) + 5'(col_q);

  always_comb begin
    state_d   = state_q;
    matrix_d  = matrix_q;
    m_d       = m_q;
    n_d       = n_q;
    row_d     = row_q;
    col_d     = col_q;
    count_d   = count_q;
    err_dim_d = 1'b0;
    err_val_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (dims_ok) begin
            m_d      = m_in;
            n_d      = n_in;
            matrix_d = '0;
            count_d  = '0;
            row_d    = '0;
            col_d    = '0;
            state_d  = COLLECT;
          end else begin
            err_dim_d = 1'b1;
          end
        end
      end

      COLLECT: begin
        // A restart request wins over an element offered in the same cycle.
        if (start) begin
          matrix_d = '0;
          count_d  = '0;
          row_d    = '0;
          col_d    = '0;
          if (dims_ok) begin
            m_d     = m_in;
            n_d     = n_in;
            state_d = COLLECT;
          end else begin
            err_dim_d = 1'b1;
            state_d   = IDLE;
          end
        end else if (elem_if.elem_valid && elem_ready_q) begin
          if (elem_reject) begin
            err_val_d = 1'b1;
          end else begin
            matrix_d[cell_idx] = elem_if.elem_data;
            count_d            = count_q + 5'd1;
            if (col_q == n_q - 3'd1) begin
              col_d = '0;
              if (row_q == m_q - 3'd1) begin
                state_d = DONE;
              end else begin
                row_d = row_q + 3'd1;
              end
            end else begin
              col_d = col_q + 3'd1;
            end
          end
        end
      end

      DONE: begin
        if (consume) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    elem_ready_d = (state_d == COLLECT);
    busy_d       = (state_d == COLLECT);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      matrix_q     <= '0;
      m_q          <= '0;
      n_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      count_q      <= '0;
      elem_ready_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_dim_q    <= 1'b0;
      err_val_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      matrix_q     <= matrix_d;
      m_q          <= m_d;
      n_q          <= n_d;
      row_q        <= row_d;
      col_q        <= col_d;
      count_q      <= count_d;
      elem_ready_q <= elem_ready_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      err_dim_q    <= err_dim_d;
      err_val_q    <= err_val_d;
    end
  end

  assign elem_if.elem_ready = elem_ready_q;
  assign matrix_out         = matrix_q;
  assign m_out              = m_q;
  assign n_out              = n_q;
  assign count              = count_q;
  assign done               = done_q;
  assign busy               = busy_q;
  assign err_dim            = err_dim_q;
  assign err_val            = err_val_q;

endmodule

// File: doc/matrix_entry_collector.md
# matrix_entry_collector

Upstream loading stage for the matrix calculation path. It accepts the matrix dimensions, then collects elements one at a time in row-major order over a valid/ready handshake, and packs them into the 25×8-bit flat bus consumed by the scalar-multiply unit and the other calculation units. It holds the finished matrix stable with `done` asserted until downstream acknowledges it.

## Interface
- `MAX_DIM`, 5: maximum rows/columns.
- `ELEM_WIDTH`, 8: bits per element.
- `MAX_VAL`, 9: largest legal element value; used only when range checking is compiled in.

- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to begin a new matrix; latches `m_in`/`n_in`.
- `m_in` in 3: row count, 1..MAX_DIM.
- `n_in` in 3: column count, 1..MAX_DIM.
- `elem_valid` in 1: `elem_data` is valid.
- `elem_data` in ELEM_WIDTH: element value.
- `elem_ready` out 1: collector accepts an element this cycle.
- `consume` in 1: downstream has taken the matrix.
- `matrix_out` out MAX_DIM²×ELEM_WIDTH (200): packed matrix; element (i,j) is at bits `[(i*MAX_DIM+j)*ELEM_WIDTH +: ELEM_WIDTH]`.
- `m_out` out 3: latched row count.
- `n_out` out 3: latched column count.
- `done` out 1: matrix is complete and stable.
- `busy` out 1: collection is in progress.
- `count` out 5: number of elements accepted so far.
- `err_dim` out 1: one-cycle pulse when dimensions are illegal.
- `err_val` out 1: one-cycle pulse when an element is out of range (only with the configuration macro defined).

## Operation
- FSM states are IDLE, COLLECT and DONE.
- **Reset values:** state is IDLE, `matrix_out`=0, `m_out`=`n_out`=0, `count`=0, and `elem_ready`, `done`, `busy`, `err_dim`, `err_val` are all 0.
- **IDLE + `start`:**
  - If `m_in` or `n_in` is 0 or greater than MAX_DIM: pulse `err_dim`, stay in IDLE, and leave all registers unchanged.
  - Otherwise: latch `m_out`/`n_out`, clear `matrix_out` and `count`, zero the row/col counters, and go to COLLECT.
- **COLLECT:**
  - `elem_ready`=1 and `busy`=1.
  - An element is accepted when `elem_valid && elem_ready`. It is written at (row, col), `count` increments, and col increments.
  - When col = `n_out`-1, col wraps to 0 and row increments.
  - Accepting element (`m_out`-1, `n_out`-1) moves the FSM to DONE.
  - Positions outside m×n always remain 0.
- **`start` during COLLECT:** the current collection is aborted and restarted with the new dimensions, using the same legality check. An illegal `start` pulses `err_dim` and returns to IDLE with `matrix_out` cleared.
- **DONE:**
  - `done`=1, `elem_ready`=0, and `matrix_out`, `m_out`, `n_out` are frozen.
  - `consume` moves the FSM to IDLE.
  - `start` is ignored until after `consume`.
- **IDLE after DONE:** `matrix_out`, `m_out`, `n_out` and `count` keep their last values until the next legal `start`.
- **Element width:** `elem_data` is stored unmodified at ELEM_WIDTH bits; no truncation or extension.

## Timing
- Registers update on the edge that samples the triggering input; outputs change in the following cycle.
- `start` → `elem_ready`=1: 1 cycle.
- Last accept → `done`=1: 1 cycle, with `elem_ready`=0 in that same cycle.
- `consume` → `done`=0: 1 cycle.
- Throughput is one element per cycle when `elem_valid` is held high. A 5×5 matrix completes 25 cycles after COLLECT is entered, and a 1×1 matrix completes 1 cycle after.
- `err_dim` and `err_val` are high for exactly one cycle, in the cycle after the offending sample.
- Reset has priority over every other input, in any state: outputs take their reset values at the next edge.
- `elem_valid` outside COLLECT is ignored.

## Configuration
- Macro: `MATRIX_RANGE_CHECK_EN`.
- **Defined:** in COLLECT, an element with `elem_valid` and `elem_data` > MAX_VAL is rejected.
  - It is not stored, and `count`, row and col do not advance.
  - `err_val` pulses.
  - `elem_ready` stays 1, so the source re-sends.
- **Undefined:** all values are accepted and `err_val` is tied to 0.

## Test plan
- Reset, then `start` with m=2, n=3, then elements 1,2,3,4,5,6 back-to-back → `done` rises 1 cycle after the 6th accept. `matrix_out` bytes 0,1,2 = 1,2,3 and bytes 5,6,7 = 4,5,6; all other bytes 0; `count`=6.
- `start` with m=0, and separately with n=6 → `err_dim` is a single-cycle pulse, state stays IDLE, `elem_ready` stays 0.
- 5×5 with `elem_valid` toggled every other cycle → 25 accepts, no duplicates or skips, and byte k equals the k-th sent value. Then `consume` → `done`=0 next cycle and `matrix_out` is unchanged.
- Abort: m=3, n=3, 4 elements accepted, then `start` with m=1, n=1 and element 7 → `done` asserted, byte 0 = 7, all other bytes 0, `m_out`=1.
- Reset asserted mid-COLLECT (after 3 elements) → next cycle all outputs are at reset values and state is IDLE.
- With `MATRIX_RANGE_CHECK_EN`: 1×2 matrix, send 12 then 4 then 8 → 12 is rejected with an `err_val` pulse; `matrix_out` bytes 0,1 = 4,8 and `done`=1.
